// File: rtl/shift_sequencer_if.sv
// Host-side control/status bundle for shift_sequencer; the tristate Data bus stays a plain inout port.
interface shift_sequencer_if #(
  parameter int unsigned Lanes      = 1,
  parameter int unsigned CountWidth = 8
);
  logic                  EN;
  logic                  WR;
  logic                  RD;
  logic [Lanes-1:0]      SI;
  logic [Lanes-1:0]      SO;
  logic                  Dir;
  logic [1:0]            Mode;
  logic                  Start;
  logic [CountWidth-1:0] Count;
  logic                  Busy;
  logic                  Done;
  logic                  Err;

  modport master (
    output EN, WR, RD, SI, Dir, Mode, Start, Count,
    input  SO, Busy, Done, Err
  );

  modport slave (
    input  EN, WR, RD, SI, Dir, Mode, Start, Count,
    output SO, Busy, Done, Err
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-lane bidirectional shift register with an autonomous Count-step sequencer.
// Optional macro SHIFT_SEQ_MSG_EN adds simulation-only messages for every Err pulse.
module shift_sequencer #(
  parameter int unsigned Length     = 8,
  parameter int unsigned Lanes      = 1,
  parameter int unsigned CountWidth = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  inout  wire  [Length-1:0] Data,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [Length-1:0]     r_reg, w_reg_nxt, w_step_reg;
  logic [Lanes-1:0]      r_so, w_so_nxt, w_step_so, w_fill;
  logic [CountWidth-1:0] r_rem, w_rem_nxt;
  logic                  r_dir, w_dir_nxt, w_use_dir;
  logic [1:0]            r_mode, w_mode_nxt, w_use_mode;
  logic                  r_busy, r_done, r_err;
  logic                  w_err_wren, w_err_wrrd, w_err_busy, w_err_mode;

  assign Data     = bus.RD ? r_reg : 'z;
  assign bus.SO   = r_so;
  assign bus.Busy = r_busy;
  assign bus.Done = r_done;
  assign bus.Err  = r_err;

  // A run uses the Dir/Mode captured at Start; manual steps use the live inputs.
  assign w_use_dir  = (r_state == S_SHIFT) ? r_dir  : bus.Dir;
  assign w_use_mode = (r_state == S_SHIFT) ? r_mode : bus.Mode;

  // One shift step; reserved mode 11 falls through to serial-in fill.
  always_comb begin
    w_fill     = bus.SI;
    w_step_so  = r_reg[Lanes-1:0];
    w_step_reg = r_reg;
    if (!w_use_dir) begin
      case (w_use_mode)
        2'b01:   w_fill = r_reg[Lanes-1:0];
        2'b10:   w_fill = {Lanes{r_reg[Length-1]}};
        default: w_fill = bus.SI;
      endcase
      w_step_so  = r_reg[Lanes-1:0];
      w_step_reg = {w_fill, r_reg[Length-1:Lanes]};
    end else begin
      case (w_use_mode)
        2'b01:   w_fill = r_reg[Length-1 -: Lanes];
        2'b10:   w_fill = '0;
        default: w_fill = bus.SI;
      endcase
      w_step_so  = r_reg[Length-1 -: Lanes];
      w_step_reg = {r_reg[Length-Lanes-1:0], w_fill};
    end
  end

  // Next-state and datapath update; DONE accepts requests exactly like IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_reg_nxt   = r_reg;
    w_so_nxt    = r_so;
    w_rem_nxt   = r_rem;
    w_dir_nxt   = r_dir;
    w_mode_nxt  = r_mode;
    w_err_wren  = 1'b0;
    w_err_wrrd  = 1'b0;
    w_err_busy  = 1'b0;
    w_err_mode  = 1'b0;
    case (r_state)
      S_SHIFT: begin
        w_reg_nxt  = w_step_reg;
        w_so_nxt   = w_step_so;
        w_rem_nxt  = r_rem - CountWidth'(1);
        w_err_busy = bus.EN | bus.WR | bus.Start;
        w_err_mode = (r_mode == 2'b11);
        if (r_rem == CountWidth'(1)) w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        if (bus.Start) begin
          w_dir_nxt  = bus.Dir;
          w_mode_nxt = bus.Mode;
          if (bus.Count == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_rem_nxt   = bus.Count;
            w_state_nxt = S_SHIFT;
          end
        end else if (bus.EN) begin
          w_reg_nxt  = w_step_reg;
          w_so_nxt   = w_step_so;
          w_err_wren = bus.WR;
          w_err_wrrd = bus.WR & bus.RD;
          w_err_mode = (bus.Mode == 2'b11);
        end else if (bus.WR) begin
          w_reg_nxt  = Data;
          w_err_wrrd = bus.RD;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_reg   <= '0;
      r_so    <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_mode  <= 2'b00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_reg   <= w_reg_nxt;
      r_so    <= w_so_nxt;
      r_rem   <= w_rem_nxt;
      r_dir   <= w_dir_nxt;
      r_mode  <= w_mode_nxt;
      r_busy  <= (w_state_nxt == S_SHIFT);
      r_done  <= (w_state_nxt == S_DONE);
      r_err   <= w_err_wren | w_err_wrrd | w_err_busy | w_err_mode;
    end
  end

`ifdef SHIFT_SEQ_MSG_EN
  always @(posedge Clk) begin
    if (!Reset) begin
      if (w_err_wren) $display("Error in module %m: WR and EN both active at time %0d", $time);
      if (w_err_wrrd) $display("Error in module %m: WR and RD both active at time %0d", $time);
      if (w_err_busy) $display("Error in module %m: request while busy at time %0d", $time);
      if (w_err_mode) $display("Error in module %m: reserved Mode at time %0d", $time);
    end
  end
`else
`endif

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Parametrised successor to the single-bit bidirectional-bus shift register. It shifts Lanes bits per step, left or right, with fill modes: serial-in, rotate, or arithmetic/zero.
An autonomous sequencer runs Count steps after a Start pulse and reports Busy/Done. Parallel load/readback still uses the shared tristate Data bus.
It sits between a parallel host bus and a serial link or bit-manipulation datapath.

Parameters:
Length, 8, register width in bits; must be a multiple of Lanes, at least 2.
Lanes, 1, bits shifted per step (SI/SO width); 1 <= Lanes < Length.
CountWidth, 8, width of Count step counter.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
EN  input  1  manual single shift step (IDLE only)
WR  input  1  parallel load Reg <= Data (IDLE only)
RD  input  1  drive Reg onto Data
Data  inout  Length  tristate parallel bus
SI  input  Lanes  serial in
SO  output  Lanes  registered serial out
Dir  input  1  0 = shift right (LSB out first), 1 = shift left (MSB out first)
Mode  input  2  00 serial-in fill, 01 rotate, 10 arithmetic/zero fill, 11 reserved
Start  input  1  begin Count-step run (IDLE only)
Count  input  CountWidth  number of steps for a run
Busy  output  1  high in SHIFT state
Done  output  1  one-cycle pulse at end of run
Err  output  1  one-cycle pulse on illegal request

Behaviour:
- Reset (sync, priority over everything): Reg=0, SO=0, Busy=0, Done=0, Err=0, state=IDLE, remaining=0. Reset mid-run aborts with no Done.
- Data = RD ? Reg : all-Z. This is combinational and legal in any state.
- One step, right (Dir=0): SO <= Reg[Lanes-1:0]; Reg <= {fill, Reg[Length-1:Lanes]}.
- Right-shift fill: Mode00 = SI; Mode01 = Reg[Lanes-1:0]; Mode10 = Lanes copies of Reg[Length-1] (arithmetic).
- One step, left (Dir=1): SO <= Reg[Length-1 -: Lanes]; Reg <= {Reg[Length-Lanes-1:0], fill}.
- Left-shift fill: Mode00 = SI; Mode01 = Reg[Length-1 -: Lanes]; Mode10 = zeros.
- Mode11 is treated as Mode00 and pulses Err on every step that uses it.
- States:
  - IDLE:
    - EN=1 performs one step. WR=1 and EN=0 loads Reg<=Data.
    - EN and WR together: EN wins, no load, Err pulse.
    - WR and RD together: load proceeds, Err pulse (bus contention).
    - Start=1: Dir and Mode are latched into internal registers, and EN/WR in that cycle are ignored.
    - Start with Count!=0: remaining<=Count, go to SHIFT.
    - Start with Count==0: Done pulses next cycle, stay IDLE, no shift.
  - SHIFT:
    - Busy=1. One step per cycle using the latched Dir/Mode; SI is sampled every cycle.
    - remaining decrements each step. The step with remaining==1 is the last; next state is DONE.
    - EN, WR and Start are ignored; any of them asserted pulses Err.
  - DONE:
    - Done=1 and Busy=0 for exactly one cycle, then IDLE. Requests here are treated as in IDLE.
- Latency: a run of N steps asserts Busy for N cycles. Done rises on the cycle after the last step.
- A Count of 2^CountWidth-1 is legal; the counter never wraps.
- SO holds its value whenever no step occurs.

Optional Feature:
SHIFT_SEQ_MSG_EN:
- Defined: every Err pulse also issues $display("Error in module %m: <cause> at time %0d", $time). Cause is one of "WR and EN both active", "WR and RD both active", "request while busy", "reserved Mode".
- Undefined: no messages; Err behaviour is identical.
- Non-synthesisable code only; no effect on the netlist.

Test Plan:
- Length=8, Lanes=1, Reset 1 cycle -> Reg=0, SO=0, Busy=0, Done=0, Data=Z with RD=0.
- Load with WR, Data=8'hA5, then RD=1 -> Data reads 8'hA5. Start, Count=8, Dir=0, Mode=01 -> SO sequence 1,0,1,0,0,1,0,1. Busy high 8 cycles, Done pulse on cycle 9, Reg=8'hA5.
- Load 8'h90, Start, Count=3, Dir=0, Mode=10 -> Reg=8'hF2, SO=0. Repeat with Dir=1, Mode=10 from 8'h90 -> Reg=8'h80, SO=0 after 3 steps.
- Lanes=2, Length=8, load 8'h1B, Start, Count=4, Dir=1, Mode=00, SI=2'b11 -> SO = 00,01,10,11; final Reg=8'hFF.
- Start Count=5, then WR=1 and EN=1 on cycle 2 -> Err pulse, Reg unaffected by WR, run completes with Done. Reset asserted on cycle 3 of a second run -> Busy drops, no Done, Reg=0.
- IDLE with EN=1 and WR=1 together -> one shift, Err pulse. Start with Count=0 -> Done pulse, Reg unchanged.
